camera_readout_sequencer: RTL
=============================

# camera_readout_sequencer

Host-side controller that sequences a 64x64 camera front end over its SPI clock line. On a start request it issues a trigger burst on SCLK and waits for the camera interrupt, with a timeout. It latches the camera's LOOKUP (frame-buffer) bit, then clocks out one SCLK burst per row, strobing each row completion to the downstream pixel capture logic. It sits between the host command logic and the camera's SCLK/INT/LOOKUP pins, in the same CLK domain as the camera.

## Interface
- DIV, 4: SCLK half-period in CLK cycles (>=1)
- BURST_LEN, 16: SCLK periods per trigger burst and per row burst (>=1)
- GAP, 64: idle CLK cycles after the trigger burst; must exceed the camera's SCLK-activity detector timeout
- RGAP, 8: idle CLK cycles between row bursts; must be below the detector timeout
- ROWS, 64: row bursts per frame (1..256)
- TIMEOUT, 24000: CLK cycles to wait for INT before error
- TW, 32: width of the gap/timeout counter
- CLK  in  1  system clock; all logic on posedge
- RST  in  1  asynchronous, active-low reset (low = reset)
- START  in  1  frame request; sampled only in IDLE
- ABORT  in  1  synchronous abort; highest priority after reset
- INT  in  1  camera interrupt, synchronous to CLK
- LOOKUP  in  1  camera frame-buffer select, synchronous to CLK
- SCLK  out  1  SPI clock to camera, registered
- BUSY  out  1  high whenever state != IDLE
- ROW_STB  out  1  one-cycle pulse at the end of each row burst
- ROW_IDX  out  8  index of the row just completed; valid with ROW_STB
- FRAME_ID  out  1  LOOKUP latched when INT is accepted
- DONE  out  1  one-cycle pulse when the frame completes
- ERR  out  1  sticky INT-timeout flag

## Operation
- States: IDLE, TRIG, TGAP, WAIT_INT, ROW, RGAP, FIN.
- IDLE: START=1 -> TRIG, clear ERR, clear row counter. START in any other state is ignored.
- TRIG: one burst of BURST_LEN SCLK periods, then -> TGAP.
- TGAP: SCLK held low for GAP cycles, then -> WAIT_INT with the timeout counter cleared.
- WAIT_INT: INT=1 -> latch FRAME_ID<=LOOKUP, -> ROW.
  - Otherwise the counter increments; at count TIMEOUT-1 -> ERR<=1, -> IDLE, no DONE.
  - If INT and timeout occur in the same cycle, INT wins.
- ROW: one burst, then ROW_STB=1 with ROW_IDX = row counter.
  - Not the last row (counter < ROWS-1): counter++, -> RGAP.
  - Last row: -> FIN.
- RGAP: SCLK low for RGAP cycles, -> ROW.
- FIN: DONE=1 for one cycle, -> IDLE.
- Burst generator:
  - SCLK is low on burst entry and toggles every DIV cycles.
  - First rising edge occurs DIV cycles after entry.
  - A burst lasts exactly 2*DIV*BURST_LEN cycles and ends with SCLK low.
- ABORT=1 in any non-IDLE state:
  - -> IDLE next cycle, SCLK low next cycle.
  - No DONE, no ROW_STB, ERR unchanged.
- Counters: row counter is 8 bits; gap/timeout counter is TW bits, with no wrap within the parameter ranges.

## Timing
- Reset values: SCLK=0, BUSY=0, ROW_STB=0, ROW_IDX=0, FRAME_ID=0, DONE=0, ERR=0, state=IDLE, counters=0.
- START sampled at cycle t:
  - BUSY=1 at t+1.
  - First SCLK rise at t+1+DIV.
- Trigger burst end to WAIT_INT entry: GAP cycles.
- INT accepted at cycle u: first row SCLK rise at u+1+DIV.
- ROW_STB asserts in the cycle after the burst's last falling edge.
- Consecutive ROW_STB pulses are 2*DIV*BURST_LEN + RGAP + 1 cycles apart.
- DONE asserts one cycle after the last ROW_STB; BUSY=0 the cycle after DONE.
- Timeout: ERR and BUSY=0 become visible TIMEOUT cycles after WAIT_INT entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-frame returns all outputs to their reset values immediately (asynchronous).

## Test plan
- Defaults, START pulse, INT raised 100 cycles into WAIT_INT with LOOKUP=1 -> 16 SCLK rises, then a 64-cycle low gap, then 64 row bursts of 16 rises each; ROW_STB with ROW_IDX 0..63 at 137-cycle spacing; FRAME_ID=1; one DONE; ERR=0.
- INT never raised, TIMEOUT=50 -> ERR=1 and BUSY=0 exactly 50 cycles after WAIT_INT entry; no ROW_STB, no DONE; next START clears ERR.
- INT rises in the same cycle the timeout would fire -> frame proceeds; ERR stays 0.
- ABORT during row 5 burst -> SCLK=0 and BUSY=0 next cycle; last ROW_IDX seen is 4; no DONE.
- START held high for the whole frame -> exactly one frame, then a new frame starts the cycle after BUSY falls. START pulsed during a frame -> ignored.
- RST driven low mid-RGAP with DIV=1, BURST_LEN=1, ROWS=2 -> all outputs reset asynchronously; after release, a START runs a complete 2-row frame.

Source files
------------

// File: rtl/camera_readout_sequencer_if.sv
// ============================================================================
// Module   : camera_readout_sequencer_if
// Brief    : Host/camera-side signal bundle of the camera readout sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface camera_readout_sequencer_if;
    logic       i_start;
    logic       i_abort;
    logic       i_int;
    logic       i_lookup;
    logic       o_sclk;
    logic       o_busy;
    logic       o_row_stb;
    logic [7:0] o_row_idx;
    logic       o_frame_id;
    logic       o_done;
    logic       o_err;

    modport master (
        output i_start, i_abort, i_int, i_lookup,
        input  o_sclk, o_busy, o_row_stb, o_row_idx, o_frame_id, o_done, o_err
    );

    modport slave (
        input  i_start, i_abort, i_int, i_lookup,
        output o_sclk, o_busy, o_row_stb, o_row_idx, o_frame_id, o_done, o_err
    );
endinterface

`default_nettype wire

// File: rtl/camera_readout_sequencer.sv
// ============================================================================
// Module   : camera_readout_sequencer
// Brief    : Trigger burst, INT wait with timeout, then one SCLK burst per row.
// Revision : 1.0
// ============================================================================
`default_nettype none

module camera_readout_sequencer #(
    parameter int DIV       = 4,
    parameter int BURST_LEN = 16,
    parameter int GAP       = 64,
    parameter int RGAP      = 8,
    parameter int ROWS      = 64,
    parameter int TIMEOUT   = 24000,
    parameter int TW        = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    camera_readout_sequencer_if.slave   bus
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EW = $clog2(2 * BURST_LEN + 1);

    localparam logic [DW-1:0] c_DIV_LAST  = DW'(DIV - 1);
    localparam logic [EW-1:0] c_EDGE_LAST = EW'(2 * BURST_LEN - 1);
    localparam logic [EW-1:0] c_EDGE_DONE = EW'(2 * BURST_LEN);
    localparam logic [TW-1:0] c_GAP_LAST  = TW'(GAP - 1);
    localparam logic [TW-1:0] c_RGAP_LAST = TW'(RGAP - 1);
    localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]    c_ROW_LAST  = 8'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_TGAP = 3'd2,
        S_WAIT = 3'd3,
        S_ROW  = 3'd4,
        S_RGAP = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [EW-1:0]   r_edges;
    logic [TW-1:0]   r_cnt;
    logic [7:0]      r_row;
    logic            r_sclk;
    logic            r_busy;
    logic            r_row_stb;
    logic [7:0]      r_row_idx;
    logic            r_frame_id;
    logic            r_done;
    logic            r_err;

    logic            w_tick;

    assign w_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_edges    <= '0;
            r_cnt      <= '0;
            r_row      <= '0;
            r_sclk     <= 1'b0;
            r_busy     <= 1'b0;
            r_row_stb  <= 1'b0;
            r_row_idx  <= '0;
            r_frame_id <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_row_stb <= 1'b0;
            r_done    <= 1'b0;
            if (r_state != S_IDLE && bus.i_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_sclk  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            r_state <= S_TRIG;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                            r_row   <= '0;
                            r_div   <= '0;
                            r_edges <= '0;
                            r_sclk  <= 1'b0;
                        end
                    end

                    S_TRIG: begin
                        if (w_tick) begin
                            r_div   <= '0;
                            r_sclk  <= ~r_sclk;
                            r_edges <= r_edges + 1'b1;
                            if (r_edges == c_EDGE_LAST) begin
                                r_state <= S_TGAP;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end

                    S_TGAP: begin
                        if (r_cnt == c_GAP_LAST) begin
                            r_state <= S_WAIT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    // INT takes precedence over a timeout landing in the same cycle.
                    S_WAIT: begin
                        if (bus.i_int) begin
                            r_frame_id <= bus.i_lookup;
                            r_state    <= S_ROW;
                            r_div      <= '0;
                            r_edges    <= '0;
                        end else if (r_cnt == c_TO_LAST) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    // The extra settle cycle after the last falling edge carries the strobe.
                    S_ROW: begin
                        if (r_edges == c_EDGE_DONE) begin
                            r_row_stb <= 1'b1;
                            r_row_idx <= r_row;
                            if (r_row == c_ROW_LAST) begin
                                r_state <= S_FIN;
                            end else begin
                                r_row   <= r_row + 1'b1;
                                r_cnt   <= '0;
                                r_state <= S_RGAP;
                            end
                        end else if (w_tick) begin
                            r_div   <= '0;
                            r_sclk  <= ~r_sclk;
                            r_edges <= r_edges + 1'b1;
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end

                    S_RGAP: begin
                        if (r_cnt == c_RGAP_LAST) begin
                            r_state <= S_ROW;
                            r_div   <= '0;
                            r_edges <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    // First FIN cycle raises DONE, second returns to IDLE.
                    S_FIN: begin
                        if (r_done) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_sclk  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_sclk     = r_sclk;
    assign bus.o_busy     = r_busy;
    assign bus.o_row_stb  = r_row_stb;
    assign bus.o_row_idx  = r_row_idx;
    assign bus.o_frame_id = r_frame_id;
    assign bus.o_done     = r_done;
    assign bus.o_err      = r_err;

endmodule

`default_nettype wire
